regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the pipeline register file: two read ports and two write ports (E and M).
- Adds per-port write enables, a "no register" address, an optional hardwired-zero register, and asynchronous active-low reset clearing.
- Adds optional write-to-read bypass and a busy scoreboard for the decode stage's hazard logic.
- Sits between decode (reads, allocation) and writeback (E/M writes).

Parameters:
- DATA_WID, 32: register data width in bits.
- ADDR_WID, 4: register address width.
- NUM_OF_REG, 15: implemented registers at addresses 0..NUM_OF_REG-1. Must be <= 2**ADDR_WID.
- NONE_REG, 15: address meaning "no register". Writes to it are ignored; reads of it return 0 and busy 0.
- ZERO_REG_EN, 0: if 1, address 0 always reads 0, is never written, and is never busy.
- BYPASS, 1: if 1, a read of an address being written in the same cycle returns the incoming write data.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- srcA  in  ADDR_WID  read address A.
- srcB  in  ADDR_WID  read address B.
- valA  out  DATA_WID  read data A (combinational).
- valB  out  DATA_WID  read data B (combinational).
- busyA  out  1  srcA has a pending producer (combinational).
- busyB  out  1  srcB has a pending producer (combinational).
- weE  in  1  write enable, port E.
- destE  in  ADDR_WID  write address, port E.
- valE  in  DATA_WID  write data, port E.
- weM  in  1  write enable, port M.
- destM  in  ADDR_WID  write address, port M.
- valM  in  DATA_WID  write data, port M.
- alloc_en  in  1  mark a destination as pending.
- alloc_dst  in  ADDR_WID  destination to mark.

Behaviour:
- Clock and reset: one clock (CLK, rising edge); reset RST_N is asynchronous and active-low.
- Reset: while RST_N=0, all registers = 0 and all busy bits = 0. Outputs follow combinationally, so valA=valB=0 and busyA=busyB=0. Deassertion takes effect at the next rising edge.
- Address validity: an address is valid if it is < NUM_OF_REG, != NONE_REG, and not (ZERO_REG_EN and address == 0).
- Write effectiveness: a write is effective if its enable=1 and its address is valid.
- Write timing: effective writes update at the rising edge of CLK; 1-cycle write-to-visible latency when BYPASS=0.
- E/M collision: both effective to the same address: M wins, E is discarded. Different addresses: both commit.
- Read, normal: combinational; an invalid address reads 0.
- Read, BYPASS=1: if src equals an effective write address this cycle, return that write's data (M over E if both match). Otherwise return stored data.
- Busy set: at the rising edge, alloc_en with a valid alloc_dst sets busy[alloc_dst].
- Busy clear: at the rising edge, each effective E/M write clears busy[dest].
- Same-edge alloc and write to the same address: alloc wins and busy stays 1 (new producer issued).
- busyA/busyB: busy[src] for a valid src, else 0.
  - BYPASS=1: additionally forced to 0 when src matches an effective write this cycle, unless alloc of that same address is also occurring this cycle.
- Reads are side-effect free; no read/write ordering hazards inside the block.
- Reset asserted mid-cycle overrides any in-flight write or alloc.

Decomposition:
- Shared header head.v: DATA_WID, ADDR_WID, NUM_OF_REG, NONE_REG defaults.
- Optional: named Y86 register indices (RSP, RNONE) as shared constants.
- Sub-module rf_scoreboard: busy-bit vector, alloc/clear priority logic, and busy lookup per read port, with the same parameters.
- Data array, write arbitration and bypass muxing stay in regfile_mp.

Test Plan:
- Reset: RST_N=0 mid-run after writes -> valA=valB=0 and busyA=busyB=0 immediately, without waiting for a clock edge.
- Basic write: weE=1, destE=3, valE=0x1234 at edge; next cycle srcA=3 -> valA=0x1234. With BYPASS=1, valA=0x1234 in the same cycle.
- Collision: weE=weM=1, destE=destM=5, valE=0xAAAA, valM=0x5555 -> reg5=0x5555, and the bypass read also returns 0x5555.
- Ignored writes: write to NONE_REG=15 and to addr 0 (ZERO_REG_EN=1) with valE=0xFFFF -> both later read 0.
- Scoreboard: alloc reg 2 -> busyB=1 for srcB=2.
  - weM write reg 2 -> busy clears; busyB=0 in the same cycle under BYPASS.
  - Same-edge alloc and write of reg 2 -> busy stays 1.
- Read-only: weE=weM=0 with random dest/val for 50 cycles -> no register changes.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_mp_pkg
// Shared constants for the multi-port register file and its scoreboard:
// default geometry, the "no register" index, and the address-validity helper
// used by both the data array and the busy scoreboard.
// -----------------------------------------------------------------------------
package regfile_mp_pkg;

   localparam int RF_DATA_WID   = 32;
   localparam int RF_ADDR_WID   = 4;
   localparam int RF_NUM_OF_REG = 15;

   // Y86 "no register" index; also the default NONE_REG.
   localparam int RNONE         = 15;

   // An address is usable only if it is implemented, is not the "no register"
   // code, and is not the hardwired zero register (when that is enabled).
   function automatic logic regValid(
      input int unsigned addr,
      input int unsigned numOfReg,
      input int unsigned noneReg,
      input logic        zeroRegEn
   );
      logic ok;
      ok = (addr < numOfReg) && (addr != noneReg) &&
           !(zeroRegEn && (addr == 32'd0));
      return ok;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Busy-bit vector for the register file. A bit is set when decode allocates a
// destination and cleared when a writeback port commits to it; allocation wins
// on the same edge because it represents a newer producer.
//
// Ports:
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   srcA, srcB        read addresses whose busy state is looked up
//   busyA, busyB      combinational busy flags for srcA / srcB
//   wrEnE, destE      effective (already validated) write, port E
//   wrEnM, destM      effective (already validated) write, port M
//   allocEn, allocDst raw allocation request from decode
// -----------------------------------------------------------------------------
module rf_scoreboard
   import regfile_mp_pkg::*;
#(
   parameter int ADDR_WID    = RF_ADDR_WID,
   parameter int NUM_OF_REG  = RF_NUM_OF_REG,
   parameter int NONE_REG    = RNONE,
   parameter int ZERO_REG_EN = 0,
   parameter int BYPASS      = 1
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [ADDR_WID-1:0] srcA,
   input  logic [ADDR_WID-1:0] srcB,
   output logic                busyA,
   output logic                busyB,
   input  logic                wrEnE,
   input  logic [ADDR_WID-1:0] destE,
   input  logic                wrEnM,
   input  logic [ADDR_WID-1:0] destM,
   input  logic                allocEn,
   input  logic [ADDR_WID-1:0] allocDst
);

   localparam int REG_SLOTS = 2 ** ADDR_WID;

   logic [REG_SLOTS-1:0] busyR;
   logic [REG_SLOTS-1:0] busyNext;
   logic                 allocEff;
   logic                 validA;
   logic                 validB;
   logic                 hitA;
   logic                 hitB;
   logic                 allocHitA;
   logic                 allocHitB;

   // Address qualification for allocation and for both lookups.
   always_comb begin
      allocEff = allocEn && regValid(32'(allocDst), NUM_OF_REG, NONE_REG, ZERO_REG_EN != 0);
      validA   = regValid(32'(srcA), NUM_OF_REG, NONE_REG, ZERO_REG_EN != 0);
      validB   = regValid(32'(srcB), NUM_OF_REG, NONE_REG, ZERO_REG_EN != 0);
   end

   // Next busy vector: alloc sets, writes clear, alloc has priority.
   always_comb begin
      busyNext = busyR;
      for (int i = 0; i < REG_SLOTS; i++) begin
         busyNext[i] = (allocEff && (allocDst == ADDR_WID'(i))) ||
                       (busyR[i] &&
                        !(wrEnE && (destE == ADDR_WID'(i))) &&
                        !(wrEnM && (destM == ADDR_WID'(i))));
      end
   end

   // Busy vector state; cleared by reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         busyR <= '0;
      end else begin
         busyR <= busyNext;
      end
   end

   // Lookup per read port. With bypass, a producer completing this cycle
   // hides its busy bit unless a new producer is allocated at the same time.
   always_comb begin
      hitA      = (wrEnE && (destE == srcA)) || (wrEnM && (destM == srcA));
      hitB      = (wrEnE && (destE == srcB)) || (wrEnM && (destM == srcB));
      allocHitA = allocEff && (allocDst == srcA);
      allocHitB = allocEff && (allocDst == srcB);
      busyA     = validA && busyR[srcA] && !((BYPASS != 0) && hitA && !allocHitA);
      busyB     = validB && busyR[srcB] && !((BYPASS != 0) && hitB && !allocHitB);
   end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Two-read / two-write register file between decode and writeback, with a
// "no register" address, optional hardwired zero register, optional
// write-to-read bypass and a busy scoreboard for hazard detection.
//
// Ports:
//   CLK, RST_N               clock (rising edge), asynchronous active-low reset
//   srcA, srcB               read addresses
//   valA, valB               combinational read data
//   busyA, busyB             combinational "pending producer" flags
//   weE, destE, valE         write port E
//   weM, destM, valM         write port M (wins over E on the same address)
//   alloc_en, alloc_dst      mark a destination as pending
// -----------------------------------------------------------------------------
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_WID    = RF_DATA_WID,
   parameter int ADDR_WID    = RF_ADDR_WID,
   parameter int NUM_OF_REG  = RF_NUM_OF_REG,
   parameter int NONE_REG    = RNONE,
   parameter int ZERO_REG_EN = 0,
   parameter int BYPASS      = 1
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [ADDR_WID-1:0] srcA,
   input  logic [ADDR_WID-1:0] srcB,
   output logic [DATA_WID-1:0] valA,
   output logic [DATA_WID-1:0] valB,
   output logic                busyA,
   output logic                busyB,
   input  logic                weE,
   input  logic [ADDR_WID-1:0] destE,
   input  logic [DATA_WID-1:0] valE,
   input  logic                weM,
   input  logic [ADDR_WID-1:0] destM,
   input  logic [DATA_WID-1:0] valM,
   input  logic                alloc_en,
   input  logic [ADDR_WID-1:0] alloc_dst
);

   localparam int REG_SLOTS = 2 ** ADDR_WID;

   // Slots that are never valid are never written and stay at their reset 0.
   logic [DATA_WID-1:0] regArr [REG_SLOTS];

   logic effE;
   logic effM;
   logic validA;
   logic validB;

   // Effective writes; gated by RST_N so a write presented during reset is
   // neither committed nor bypassed to the read ports.
   always_comb begin
      effE   = RST_N && weE && regValid(32'(destE), NUM_OF_REG, NONE_REG, ZERO_REG_EN != 0);
      effM   = RST_N && weM && regValid(32'(destM), NUM_OF_REG, NONE_REG, ZERO_REG_EN != 0);
      validA = regValid(32'(srcA), NUM_OF_REG, NONE_REG, ZERO_REG_EN != 0);
      validB = regValid(32'(srcB), NUM_OF_REG, NONE_REG, ZERO_REG_EN != 0);
   end

   // Data array commit; E is dropped when M targets the same register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < REG_SLOTS; i++) begin
            regArr[i] <= '0;
         end
      end else begin
         if (effE && !(effM && (destM == destE))) begin
            regArr[destE] <= valE;
         end
         if (effM) begin
            regArr[destM] <= valM;
         end
      end
   end

   // Read port A: invalid reads 0, bypass prefers M over E.
   always_comb begin
      valA = '0;
      if (!validA) begin
         valA = '0;
      end else if ((BYPASS != 0) && effM && (destM == srcA)) begin
         valA = valM;
      end else if ((BYPASS != 0) && effE && (destE == srcA)) begin
         valA = valE;
      end else begin
         valA = regArr[srcA];
      end
   end

   // Read port B: same selection as port A.
   always_comb begin
      valB = '0;
      if (!validB) begin
         valB = '0;
      end else if ((BYPASS != 0) && effM && (destM == srcB)) begin
         valB = valM;
      end else if ((BYPASS != 0) && effE && (destE == srcB)) begin
         valB = valE;
      end else begin
         valB = regArr[srcB];
      end
   end

   rf_scoreboard #(
      .ADDR_WID    (ADDR_WID),
      .NUM_OF_REG  (NUM_OF_REG),
      .NONE_REG    (NONE_REG),
      .ZERO_REG_EN (ZERO_REG_EN),
      .BYPASS      (BYPASS)
   ) uScoreboard (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .srcA     (srcA),
      .srcB     (srcB),
      .busyA    (busyA),
      .busyB    (busyB),
      .wrEnE    (effE),
      .destE    (destE),
      .wrEnM    (effM),
      .destM    (destM),
      .allocEn  (RST_N && alloc_en),
      .allocDst (alloc_dst)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed bench for regfile_mp. Two instances share all inputs:
//   u0: ZERO_REG_EN=1, BYPASS=1   (outputs valA/valB/busyA/busyB)
//   u1: ZERO_REG_EN=0, BYPASS=0   (outputs valA1/valB1/busyA1/busyB1)
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

   logic        CLK;
   logic        RST_N;
   logic [3:0]  srcA, srcB, destE, destM, alloc_dst;
   logic [31:0] valE, valM;
   logic        weE, weM, alloc_en;
   logic [31:0] valA, valB, valA1, valB1;
   logic        busyA, busyB, busyA1, busyB1;

   int checks;
   int fails;

   regfile_mp #(.ZERO_REG_EN(1), .BYPASS(1)) u0 (
      .CLK(CLK), .RST_N(RST_N), .srcA(srcA), .srcB(srcB),
      .valA(valA), .valB(valB), .busyA(busyA), .busyB(busyB),
      .weE(weE), .destE(destE), .valE(valE),
      .weM(weM), .destM(destM), .valM(valM),
      .alloc_en(alloc_en), .alloc_dst(alloc_dst)
   );

   regfile_mp #(.ZERO_REG_EN(0), .BYPASS(0)) u1 (
      .CLK(CLK), .RST_N(RST_N), .srcA(srcA), .srcB(srcB),
      .valA(valA1), .valB(valB1), .busyA(busyA1), .busyB(busyB1),
      .weE(weE), .destE(destE), .valE(valE),
      .weM(weM), .destM(destM), .valM(valM),
      .alloc_en(alloc_en), .alloc_dst(alloc_dst)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic idleInputs();
      weE = 1'b0; weM = 1'b0; alloc_en = 1'b0;
      destE = 4'd0; destM = 4'd0; alloc_dst = 4'd0;
      valE = 32'd0; valM = 32'd0;
   endtask

   task automatic test_reset();
      srcA = 4'd3; srcB = 4'd2;
      #1;
      checks++; if (valA !== 32'd0) begin fails++; $display("FAIL reset_valA: got %h want %h", valA, 32'd0); end
      checks++; if (valB1 !== 32'd0) begin fails++; $display("FAIL reset_valB1: got %h want %h", valB1, 32'd0); end
      checks++; if (busyA !== 1'b0 || busyB !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b%b want 00", busyA, busyB); end
   endtask

   task automatic test_basic_write();
      @(negedge CLK);
      weE = 1'b1; destE = 4'd3; valE = 32'h1234; srcA = 4'd3;
      #1;
      checks++; if (valA !== 32'h1234) begin fails++; $display("FAIL basic_bypass: got %h want %h", valA, 32'h1234); end
      checks++; if (valA1 !== 32'd0) begin fails++; $display("FAIL basic_nobypass_old: got %h want %h", valA1, 32'd0); end
      @(negedge CLK);
      idleInputs();
      #1;
      checks++; if (valA !== 32'h1234) begin fails++; $display("FAIL basic_stored_u0: got %h want %h", valA, 32'h1234); end
      checks++; if (valA1 !== 32'h1234) begin fails++; $display("FAIL basic_stored_u1: got %h want %h", valA1, 32'h1234); end
   endtask

   task automatic test_collision();
      @(negedge CLK);
      weE = 1'b1; destE = 4'd5; valE = 32'hAAAA;
      weM = 1'b1; destM = 4'd5; valM = 32'h5555;
      srcB = 4'd5;
      #1;
      checks++; if (valB !== 32'h5555) begin fails++; $display("FAIL collide_bypass: got %h want %h", valB, 32'h5555); end
      checks++; if (valB1 !== 32'd0) begin fails++; $display("FAIL collide_nobypass_old: got %h want %h", valB1, 32'd0); end
      @(negedge CLK);
      idleInputs();
      #1;
      checks++; if (valB !== 32'h5555) begin fails++; $display("FAIL collide_stored_u0: got %h want %h", valB, 32'h5555); end
      checks++; if (valB1 !== 32'h5555) begin fails++; $display("FAIL collide_stored_u1: got %h want %h", valB1, 32'h5555); end
   endtask

   task automatic test_ignored_writes();
      @(negedge CLK);
      weE = 1'b1; destE = 4'd15; valE = 32'hFFFF;
      weM = 1'b1; destM = 4'd0;  valM = 32'hFFFF;
      srcA = 4'd15; srcB = 4'd0;
      #1;
      checks++; if (valA !== 32'd0) begin fails++; $display("FAIL none_bypass: got %h want %h", valA, 32'd0); end
      checks++; if (valB !== 32'd0) begin fails++; $display("FAIL zero_bypass: got %h want %h", valB, 32'd0); end
      @(negedge CLK);
      idleInputs();
      #1;
      checks++; if (valA !== 32'd0) begin fails++; $display("FAIL none_stored: got %h want %h", valA, 32'd0); end
      checks++; if (valB !== 32'd0) begin fails++; $display("FAIL zero_stored: got %h want %h", valB, 32'd0); end
      checks++; if (valA1 !== 32'd0) begin fails++; $display("FAIL none_stored_u1: got %h want %h", valA1, 32'd0); end
      checks++; if (valB1 !== 32'hFFFF) begin fails++; $display("FAIL reg0_plain_u1: got %h want %h", valB1, 32'hFFFF); end
   endtask

   task automatic test_scoreboard();
      @(negedge CLK);
      alloc_en = 1'b1; alloc_dst = 4'd2; srcA = 4'd15; srcB = 4'd2;
      #1;
      checks++; if (busyB !== 1'b0) begin fails++; $display("FAIL alloc_not_yet: got %b want 0", busyB); end
      @(negedge CLK);
      alloc_dst = 4'd15;
      #1;
      checks++; if (busyB !== 1'b1 || busyB1 !== 1'b1) begin fails++; $display("FAIL alloc_set: got %b%b want 11", busyB, busyB1); end
      @(negedge CLK);
      alloc_en = 1'b0;
      weM = 1'b1; destM = 4'd2; valM = 32'h77;
      #1;
      checks++; if (busyA !== 1'b0) begin fails++; $display("FAIL alloc_none_busy: got %b want 0", busyA); end
      checks++; if (busyB !== 1'b0) begin fails++; $display("FAIL clear_bypass: got %b want 0", busyB); end
      checks++; if (busyB1 !== 1'b1) begin fails++; $display("FAIL clear_nobypass: got %b want 1", busyB1); end
      @(negedge CLK);
      idleInputs();
      #1;
      checks++; if (busyB !== 1'b0 || busyB1 !== 1'b0) begin fails++; $display("FAIL clear_done: got %b%b want 00", busyB, busyB1); end
      checks++; if (valB1 !== 32'h77) begin fails++; $display("FAIL clear_data: got %h want %h", valB1, 32'h77); end
      // Same-edge alloc and write while not busy.
      @(negedge CLK);
      alloc_en = 1'b1; alloc_dst = 4'd2;
      weE = 1'b1; destE = 4'd2; valE = 32'h88;
      #1;
      checks++; if (busyB !== 1'b0) begin fails++; $display("FAIL same_edge_pre: got %b want 0", busyB); end
      checks++; if (valB !== 32'h88) begin fails++; $display("FAIL same_edge_bypass: got %h want %h", valB, 32'h88); end
      @(negedge CLK);
      idleInputs();
      #1;
      checks++; if (busyB !== 1'b1 || busyB1 !== 1'b1) begin fails++; $display("FAIL same_edge_alloc_wins: got %b%b want 11", busyB, busyB1); end
      checks++; if (valB1 !== 32'h88) begin fails++; $display("FAIL same_edge_data: got %h want %h", valB1, 32'h88); end
      // Same-edge alloc and write while already busy: no bypass masking.
      @(negedge CLK);
      alloc_en = 1'b1; alloc_dst = 4'd2;
      weM = 1'b1; destM = 4'd2; valM = 32'h99;
      #1;
      checks++; if (busyB !== 1'b1) begin fails++; $display("FAIL realloc_unmasked: got %b want 1", busyB); end
      @(negedge CLK);
      idleInputs();
      #1;
      checks++; if (busyB1 !== 1'b1) begin fails++; $display("FAIL realloc_held: got %b want 1", busyB1); end
      checks++; if (valB1 !== 32'h99) begin fails++; $display("FAIL realloc_data: got %h want %h", valB1, 32'h99); end
   endtask

   task automatic test_read_only();
      srcA = 4'd3;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         weE = 1'b0; weM = 1'b0;
         destE = 4'($urandom_range(0, 15)); valE = $urandom;
         destM = 4'($urandom_range(0, 15)); valM = $urandom;
         #1;
         checks++; if (valA1 !== 32'h1234) begin fails++; $display("FAIL readonly_cycle%0d: got %h want %h", i, valA1, 32'h1234); end
      end
      @(negedge CLK);
      idleInputs();
      srcA = 4'd5; srcB = 4'd2;
      #1;
      checks++; if (valA1 !== 32'h5555) begin fails++; $display("FAIL readonly_r5: got %h want %h", valA1, 32'h5555); end
      checks++; if (valB !== 32'h99) begin fails++; $display("FAIL readonly_r2: got %h want %h", valB, 32'h99); end
   endtask

   task automatic test_reset_mid();
      @(negedge CLK);
      srcA = 4'd3; srcB = 4'd2;
      weE = 1'b1; destE = 4'd3; valE = 32'h99;
      alloc_en = 1'b1; alloc_dst = 4'd3;
      #1;
      RST_N = 1'b0;
      #1;
      checks++; if (valA !== 32'd0 || valB !== 32'd0) begin fails++; $display("FAIL midreset_val: got %h %h want 0 0", valA, valB); end
      checks++; if (busyB !== 1'b0 || busyB1 !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b%b want 00", busyB, busyB1); end
      checks++; if (valA1 !== 32'd0) begin fails++; $display("FAIL midreset_val_u1: got %h want %h", valA1, 32'd0); end
      @(negedge CLK);
      @(negedge CLK);
      idleInputs();
      RST_N = 1'b1;
      @(negedge CLK);
      #1;
      checks++; if (valA1 !== 32'd0 || busyA1 !== 1'b0) begin fails++; $display("FAIL postreset_r3: got %h %b want 0 0", valA1, busyA1); end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      RST_N  = 1'b0;
      srcA   = 4'd0;
      srcB   = 4'd0;
      idleInputs();
      repeat (2) @(negedge CLK);
      test_reset();
      @(negedge CLK);
      RST_N = 1'b1;
      test_basic_write();
      test_collision();
      test_ignored_writes();
      test_scoreboard();
      test_read_only();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
